// File: rtl/layer_2_argmax_classifier_if.sv
// Bundle between the layer-2 pipeline and the argmax classifier: start level,
// the ten signed class scores, and the registered result/status outputs.
interface layer_2_argmax_classifier_if #(
    parameter int IN_SIZE  = 81,
    parameter int IDX_SIZE = 4
);
    logic                       load;
    logic signed [IN_SIZE-1:0]  layer_2_output_leaky_1;
    logic signed [IN_SIZE-1:0]  layer_2_output_leaky_2;
    logic signed [IN_SIZE-1:0]  layer_2_output_leaky_3;
    logic signed [IN_SIZE-1:0]  layer_2_output_leaky_4;
    logic signed [IN_SIZE-1:0]  layer_2_output_leaky_5;
    logic signed [IN_SIZE-1:0]  layer_2_output_leaky_6;
    logic signed [IN_SIZE-1:0]  layer_2_output_leaky_7;
    logic signed [IN_SIZE-1:0]  layer_2_output_leaky_8;
    logic signed [IN_SIZE-1:0]  layer_2_output_leaky_9;
    logic signed [IN_SIZE-1:0]  layer_2_output_leaky_10;
    logic [IDX_SIZE-1:0]        class_index;
    logic signed [IN_SIZE-1:0]  max_value;
    logic                       busy;
    logic                       done;

    modport master (
        output load,
        output layer_2_output_leaky_1, layer_2_output_leaky_2, layer_2_output_leaky_3,
               layer_2_output_leaky_4, layer_2_output_leaky_5, layer_2_output_leaky_6,
               layer_2_output_leaky_7, layer_2_output_leaky_8, layer_2_output_leaky_9,
               layer_2_output_leaky_10,
        input  class_index, max_value, busy, done
    );

    modport slave (
        input  load,
        input  layer_2_output_leaky_1, layer_2_output_leaky_2, layer_2_output_leaky_3,
               layer_2_output_leaky_4, layer_2_output_leaky_5, layer_2_output_leaky_6,
               layer_2_output_leaky_7, layer_2_output_leaky_8, layer_2_output_leaky_9,
               layer_2_output_leaky_10,
        output class_index, max_value, busy, done
    );
endinterface

// File: rtl/layer_2_argmax_classifier.sv
// Captures the ten layer-2 scores on a rising edge of load, then scans them one
// per clock for the signed maximum; lowest index wins ties.
module layer_2_argmax_classifier #(
    parameter int IN_SIZE     = 81,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_SIZE    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    layer_2_argmax_classifier_if.slave    bus
);
    localparam int CNT_W = $clog2(NUM_CLASSES);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic                       load_q, load_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [IN_SIZE-1:0]  best_val_q, best_val_d;
    logic [IDX_SIZE-1:0]        best_idx_q, best_idx_d;
    logic [IDX_SIZE-1:0]        class_index_q, class_index_d;
    logic signed [IN_SIZE-1:0]  max_value_q, max_value_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic signed [IN_SIZE-1:0]  cap_q [NUM_CLASSES];
    logic signed [IN_SIZE-1:0]  cap_d [NUM_CLASSES];
    logic signed [IN_SIZE-1:0]  in_vec [NUM_CLASSES];

    logic                       start;
    logic signed [IN_SIZE-1:0]  cur_val;
    logic signed [IN_SIZE-1:0]  nxt_val;
    logic [IDX_SIZE-1:0]        nxt_idx;

    // Port _1 is class 0, _10 is class 9.
    assign in_vec[0] = bus.layer_2_output_leaky_1;
    assign in_vec[1] = bus.layer_2_output_leaky_2;
    assign in_vec[2] = bus.layer_2_output_leaky_3;
    assign in_vec[3] = bus.layer_2_output_leaky_4;
    assign in_vec[4] = bus.layer_2_output_leaky_5;
    assign in_vec[5] = bus.layer_2_output_leaky_6;
    assign in_vec[6] = bus.layer_2_output_leaky_7;
    assign in_vec[7] = bus.layer_2_output_leaky_8;
    assign in_vec[8] = bus.layer_2_output_leaky_9;
    assign in_vec[9] = bus.layer_2_output_leaky_10;

    assign start = bus.load & ~load_q;

    always_comb begin
        cur_val = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (cnt_q == CNT_W'(i)) cur_val = cap_q[i];
        end
    end

    always_comb begin
        state_d       = state_q;
        load_d        = bus.load;
        cnt_d         = cnt_q;
        best_val_d    = best_val_q;
        best_idx_d    = best_idx_q;
        class_index_d = class_index_q;
        max_value_d   = max_value_q;
        busy_d        = busy_q;
        done_d        = done_q;
        cap_d         = cap_q;
        nxt_val       = best_val_q;
        nxt_idx       = best_idx_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cap_d      = in_vec;
                    best_val_d = in_vec[0];
                    best_idx_d = '0;
                    cnt_d      = CNT_W'(1);
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    state_d    = S_SCAN;
                end
            end
            S_SCAN: begin
                // Strict compare keeps the earlier index on a tie.
                if (cur_val > best_val_q) begin
                    nxt_val = cur_val;
                    nxt_idx = IDX_SIZE'(cnt_q);
                end
                best_val_d = nxt_val;
                best_idx_d = nxt_idx;
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NUM_CLASSES - 1)) begin
                    class_index_d = nxt_idx;
                    max_value_d   = nxt_val;
                    busy_d        = 1'b0;
                    done_d        = 1'b1;
                    state_d       = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            load_q        <= 1'b0;
            cnt_q         <= '0;
            best_val_q    <= '0;
            best_idx_q    <= '0;
            class_index_q <= '0;
            max_value_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_q        <= load_d;
            cnt_q         <= cnt_d;
            best_val_q    <= best_val_d;
            best_idx_q    <= best_idx_d;
            class_index_q <= class_index_d;
            max_value_q   <= max_value_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_cap
            always_ff @(posedge clk) begin
                if (reset) cap_q[gi] <= '0;
                else       cap_q[gi] <= cap_d[gi];
            end
        end
    endgenerate

    assign bus.class_index = class_index_q;
    assign bus.max_value   = max_value_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_layer_2_argmax_classifier.sv
// Directed bench: stimulus pushes hand-computed results into a queue, and a
// negedge monitor pops one entry per rising edge of done and compares.
module tb_layer_2_argmax_classifier;
    typedef logic signed [80:0] score_t;
    typedef struct {
        logic [3:0] idx;
        score_t     val;
        int         start_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    logic done_prev = 1'b0;
    score_t sc [10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    layer_2_argmax_classifier_if #(.IN_SIZE(81), .IDX_SIZE(4)) bus ();

    layer_2_argmax_classifier #(.IN_SIZE(81), .NUM_CLASSES(10), .IDX_SIZE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string name, input score_t actual, input score_t expected);
        n_checks++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic apply_scores();
        bus.layer_2_output_leaky_1  = sc[0];
        bus.layer_2_output_leaky_2  = sc[1];
        bus.layer_2_output_leaky_3  = sc[2];
        bus.layer_2_output_leaky_4  = sc[3];
        bus.layer_2_output_leaky_5  = sc[4];
        bus.layer_2_output_leaky_6  = sc[5];
        bus.layer_2_output_leaky_7  = sc[6];
        bus.layer_2_output_leaky_8  = sc[7];
        bus.layer_2_output_leaky_9  = sc[8];
        bus.layer_2_output_leaky_10 = sc[9];
    endtask

    task automatic push_exp(input logic [3:0] idx, input score_t val);
        exp_t e;
        e.idx = idx;
        e.val = val;
        e.start_cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    // One-cycle load pulse, then count busy cycles over a window longer than a scan.
    task automatic pulse_and_count(input logic [3:0] idx, input score_t val, input string name);
        int busy_cnt;
        push_exp(idx, val);
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
        end
        check({name, " busy_cycles"}, score_t'(busy_cnt), score_t'(9));
    endtask

    task automatic check_reset_state(input string name);
        check({name, " class_index"}, score_t'(bus.class_index), '0);
        check({name, " max_value"}, bus.max_value, '0);
        check({name, " busy"}, score_t'(bus.busy), '0);
        check({name, " done"}, score_t'(bus.done), '0);
    endtask

    task automatic set_ramp();
        for (int i = 0; i < 10; i++) sc[i] = score_t'(10 * (i + 1));
        apply_scores();
    endtask

    task automatic set_negative();
        for (int i = 0; i < 10; i++) sc[i] = -81'sd1000;
        sc[0] = -81'sd5; sc[1] = -81'sd3; sc[2] = -81'sd900; sc[3] = -81'sd3; sc[4] = -81'sd7;
        apply_scores();
    endtask

    task automatic set_extremes();
        score_t pos;
        score_t neg;
        pos = '0; pos[79] = 1'b1;
        neg = '0; neg[80] = 1'b1;
        for (int i = 0; i < 10; i++) sc[i] = neg;
        sc[0] = pos;
        apply_scores();
    endtask

    // Monitor: one scoreboard entry per rising edge of done.
    always @(negedge clk) begin
        if (!reset && bus.done && !done_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", score_t'(1), score_t'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("class_index", score_t'(bus.class_index), score_t'(e.idx));
                check("max_value", bus.max_value, e.val);
                check("latency", score_t'(cyc - e.start_cyc), score_t'(9));
                $display("result: class_index=%0d max_value=%0d at cycle %0d", bus.class_index, bus.max_value, cyc);
            end
        end
        done_prev <= bus.done;
    end

    initial begin
        score_t ext;
        ext = '0; ext[79] = 1'b1;
        reset = 1'b1;
        bus.load = 1'b0;
        for (int i = 0; i < 10; i++) sc[i] = '0;
        apply_scores();
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        @(negedge clk);

        // Ascending scores: class 9 wins.
        set_ramp();
        pulse_and_count(4'd9, 81'sd100, "ramp");

        // All negative with a tie at -3: class 1 wins.
        set_negative();
        pulse_and_count(4'd1, -81'sd3, "negative");

        // Full-width extremes: +2^79 against -2^80.
        set_extremes();
        pulse_and_count(4'd0, ext, "extremes");

        // Load held high for 30 cycles yields one scan only.
        set_ramp();
        push_exp(4'd9, 81'sd100);
        bus.load = 1'b1;
        repeat (30) @(negedge clk);
        check("held done", score_t'(bus.done), score_t'(1));
        check("held busy", score_t'(bus.busy), score_t'(0));
        bus.load = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) sc[i] = 81'sd1;
        sc[4] = 81'sd50;
        apply_scores();
        push_exp(4'd4, 81'sd50);
        bus.load = 1'b1;
        @(negedge clk);
        check("restart done_cleared", score_t'(bus.done), score_t'(0));
        check("restart class_index_held", score_t'(bus.class_index), score_t'(9));
        bus.load = 1'b0;
        repeat (11) @(negedge clk);

        // Second rising edge mid-scan with new inputs is ignored.
        set_negative();
        push_exp(4'd1, -81'sd3);
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (2) @(negedge clk);
        set_ramp();
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (10) @(negedge clk);

        // Reset mid-scan aborts; a fresh scan afterwards completes.
        set_ramp();
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("midscan_reset");
        reset = 1'b0;
        @(negedge clk);
        set_extremes();
        pulse_and_count(4'd0, ext, "after_reset");

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) check("pending_results", score_t'(exp_q.size()), score_t'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
